mul_flag_unit: RTL and testbench

Iterative 32×32 multiply unit for the execute stage. It produces the result and the NZCV flag vector that the condition/flag-write logic consumes on its ALUFlags input. Operations are MUL, MLA, UMULL and SMULL, computed by radix-2 shift-add over 32 cycles. A start/busy/done handshake lets the hazard logic stall the pipeline while the unit is working.

---
 rtl/mul_flag_if.sv | 32 +++
 rtl/mul_flag_unit.sv | 173 +++++++++++++++++
 tb/tb_mul_flag_unit.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/mul_flag_if.sv
// Request/result bundle for the iterative multiply unit.
// The master issues operations; the slave (multiplier) returns result and flags.
interface mul_flag_if #(
  parameter int WIDTH = 32
);
  logic             Start;
  logic [1:0]       Op;
  logic [WIDTH-1:0] SrcA;
  logic [WIDTH-1:0] SrcB;
  logic [WIDTH-1:0] SrcAcc;
  logic [1:0]       FlagsCV;
  logic             Flush;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] ResultLo;
  logic [WIDTH-1:0] ResultHi;
  logic [3:0]       ALUFlags;

  modport master (
    output Start, Op, SrcA, SrcB,
    output SrcAcc, FlagsCV, Flush,
    input  Busy, Done, ResultLo,
    input  ResultHi, ALUFlags
  );

  modport slave (
    input  Start, Op, SrcA, SrcB,
    input  SrcAcc, FlagsCV, Flush,
    output Busy, Done, ResultLo,
    output ResultHi, ALUFlags
  );
endinterface

// File: rtl/mul_flag_unit.sv
// Iterative radix-2 shift-add multiplier (MUL/MLA/UMULL/SMULL)
// producing a result and NZCV flags with a start/busy/done handshake.
module mul_flag_unit #(
  parameter int WIDTH = 32
) (
  input  logic        clk,
  input  logic        reset,
  mul_flag_if.slave   bus
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [1:0] OP_MUL   = 2'b00;
  localparam logic [1:0] OP_MLA   = 2'b01;
  localparam logic [1:0] OP_UMULL = 2'b10;
  localparam logic [1:0] OP_SMULL = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_e;

  state_e             state_q;
  logic [1:0]         op_q;
  logic [1:0]         cv_q;
  logic [WIDTH-1:0]   acc_in_q;
  logic               sign_q;
  logic [2*WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [2*WIDTH-1:0] prod_q;
  logic [CW-1:0]      cnt_q;
  logic               fin_q;
  logic               busy_q;
  logic               done_q;
  logic [WIDTH-1:0]   lo_q;
  logic [WIDTH-1:0]   hi_q;
  logic [3:0]         flags_q;

  logic               is_smull;
  logic               neg_a;
  logic               neg_b;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;

  // Signed long form works on magnitudes; 0x80000000 negates to itself,
  // which is exactly its unsigned magnitude.
  always_comb begin
    is_smull = (bus.Op == OP_SMULL);
    neg_a    = is_smull & bus.SrcA[WIDTH-1];
    neg_b    = is_smull & bus.SrcB[WIDTH-1];
    mag_a    = neg_a ? ('0 - bus.SrcA) : bus.SrcA;
    mag_b    = neg_b ? ('0 - bus.SrcB) : bus.SrcB;
  end

  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   lo_d;
  logic [WIDTH-1:0]   hi_d;
  logic [3:0]         flags_d;

  always_comb begin
    prod_s  = sign_q ? ('0 - prod_q) : prod_q;
    lo_d    = prod_s[WIDTH-1:0];
    hi_d    = '0;
    flags_d = {2'b00, cv_q};
    unique case (op_q)
      OP_MUL: begin
        lo_d    = prod_s[WIDTH-1:0];
        flags_d = {lo_d[WIDTH-1], ~|lo_d, cv_q};
      end
      OP_MLA: begin
        lo_d    = prod_s[WIDTH-1:0] + acc_in_q;
        flags_d = {lo_d[WIDTH-1], ~|lo_d, cv_q};
      end
      OP_UMULL, OP_SMULL: begin
        lo_d    = prod_s[WIDTH-1:0];
        hi_d    = prod_s[2*WIDTH-1:WIDTH];
        flags_d = {hi_d[WIDTH-1], ~|prod_s, cv_q};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      op_q     <= '0;
      cv_q     <= '0;
      acc_in_q <= '0;
      sign_q   <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
      fin_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      lo_q     <= '0;
      hi_q     <= '0;
      flags_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          fin_q  <= 1'b0;
          if (!bus.Flush && bus.Start) begin
            op_q     <= bus.Op;
            cv_q     <= bus.FlagsCV;
            acc_in_q <= bus.SrcAcc;
            sign_q   <= neg_a ^ neg_b;
            mcand_q  <= {{WIDTH{1'b0}}, mag_a};
            mplier_q <= mag_b;
            prod_q   <= '0;
            cnt_q    <= '0;
            state_q  <= BUSY;
            busy_q   <= 1'b1;
          end
        end
        BUSY: begin
          if (bus.Flush) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            if (mplier_q[0]) begin
              prod_q <= prod_q + mcand_q;
            end
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + 1'b1;
            if (cnt_q == LAST) begin
              state_q <= DONE;
              fin_q   <= 1'b0;
            end
          end
        end
        DONE: begin
          // First DONE cycle latches results; second returns to IDLE
          // so Busy covers the Done pulse.
          if (bus.Flush) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            fin_q   <= 1'b0;
          end else if (!fin_q) begin
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            flags_q <= flags_d;
            done_q  <= 1'b1;
            fin_q   <= 1'b1;
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            fin_q   <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.Busy     = busy_q;
  assign bus.Done     = done_q;
  assign bus.ResultLo = lo_q;
  assign bus.ResultHi = hi_q;
  assign bus.ALUFlags = flags_q;

endmodule

// File: tb/tb_mul_flag_unit.sv
// Directed bench for mul_flag_unit: vector table plus
// hand-written start-in-busy, flush and reset sequences.
module tb_mul_flag_unit;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  mul_flag_if bus ();

  mul_flag_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] acc;
    logic [1:0]  cv;
    logic [31:0] lo;
    logic [31:0] hi;
    logic [3:0]  fl;
  } vec_t;

  vec_t vt[10];

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic issue(logic [1:0] op, logic [31:0] a, logic [31:0] b,
                       logic [31:0] acc, logic [1:0] cv);
    @(negedge clk);
    bus.Start   = 1'b1;
    bus.Op      = op;
    bus.SrcA    = a;
    bus.SrcB    = b;
    bus.SrcAcc  = acc;
    bus.FlagsCV = cv;
    @(posedge clk);
    #1;
    bus.Start = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (bus.Done) break;
    end
  endtask

  task automatic run_vec(vec_t v);
    int lat;
    issue(v.op, v.a, v.b, v.acc, v.cv);
    chk({v.name, " busy_after_accept"}, 64'(bus.Busy), 64'd1);
    wait_done(lat);
    chk({v.name, " latency"}, 64'(lat), 64'd33);
    chk({v.name, " lo"}, 64'(bus.ResultLo), 64'(v.lo));
    chk({v.name, " hi"}, 64'(bus.ResultHi), 64'(v.hi));
    chk({v.name, " flags"}, 64'(bus.ALUFlags), 64'(v.fl));
    chk({v.name, " busy_in_done"}, 64'(bus.Busy), 64'd1);
    @(posedge clk);
    #1;
    chk({v.name, " done_pulse"}, 64'(bus.Done), 64'd0);
    chk({v.name, " busy_release"}, 64'(bus.Busy), 64'd0);
  endtask

  initial begin
    int dcount;
    int lat;
    vec_t last;
    vec_t mulv;

    vt[0] = '{"umull_max", 2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 2'b10,
              32'h00000001, 32'hFFFFFFFE, 4'b1010};
    vt[1] = '{"smull_neg", 2'b11, 32'hFFFFFFFE, 32'h00000003, 32'h0, 2'b00,
              32'hFFFFFFFA, 32'hFFFFFFFF, 4'b1000};
    vt[2] = '{"smull_min", 2'b11, 32'h80000000, 32'h80000000, 32'h0, 2'b01,
              32'h00000000, 32'h40000000, 4'b0001};
    vt[3] = '{"mul_wrap0", 2'b00, 32'h00010000, 32'h00010000, 32'h0, 2'b11,
              32'h00000000, 32'h00000000, 4'b0111};
    vt[4] = '{"mla_zero", 2'b01, 32'h7, 32'h6, 32'hFFFFFFD6, 2'b00,
              32'h00000000, 32'h00000000, 4'b0100};
    vt[5] = '{"smull_mix", 2'b11, 32'h7, 32'hFFFFFFFD, 32'h0, 2'b00,
              32'hFFFFFFEB, 32'hFFFFFFFF, 4'b1000};
    vt[6] = '{"umull_shift", 2'b10, 32'h12345678, 32'h10, 32'h0, 2'b00,
              32'h23456780, 32'h00000001, 4'b0000};
    vt[7] = '{"mul_neg", 2'b00, 32'hFFFFFFFF, 32'h2, 32'h0, 2'b10,
              32'hFFFFFFFE, 32'h00000000, 4'b1010};
    vt[8] = '{"smull_zero", 2'b11, 32'h0, 32'hFFFFFFFF, 32'h0, 2'b00,
              32'h00000000, 32'h00000000, 4'b0100};
    vt[9] = '{"mla_wrap", 2'b01, 32'h00010000, 32'h00010000, 32'h5, 2'b00,
              32'h00000005, 32'h00000000, 4'b0000};

    bus.Start   = 1'b0;
    bus.Op      = 2'b00;
    bus.SrcA    = '0;
    bus.SrcB    = '0;
    bus.SrcAcc  = '0;
    bus.FlagsCV = 2'b00;
    bus.Flush   = 1'b0;
    reset       = 1'b0;
    #1;
    chk("rst busy", 64'(bus.Busy), 64'd0);
    chk("rst done", 64'(bus.Done), 64'd0);
    chk("rst lo", 64'(bus.ResultLo), 64'd0);
    chk("rst hi", 64'(bus.ResultHi), 64'd0);
    chk("rst flags", 64'(bus.ALUFlags), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 10; i++) begin
      run_vec(vt[i]);
    end
    last = vt[9];

    // Start re-pulsed mid-operation must be ignored.
    issue(2'b00, 32'd3, 32'd4, 32'd0, 2'b00);
    dcount = 0;
    lat = 0;
    for (int i = 0; i < 45; i++) begin
      @(posedge clk);
      #1;
      if (bus.Done) begin
        dcount++;
        if (dcount == 1) begin
          chk("ignore latency", 64'(lat + 1), 64'd33);
          chk("ignore lo", 64'(bus.ResultLo), 64'd12);
          chk("ignore flags", 64'(bus.ALUFlags), 64'd0);
        end
      end
      lat++;
      bus.Start = 1'b0;
      if (i == 5) begin
        bus.Start   = 1'b1;
        bus.Op      = 2'b10;
        bus.SrcA    = 32'hDEAD0000;
        bus.SrcB    = 32'h0000BEEF;
        bus.FlagsCV = 2'b11;
      end
    end
    chk("ignore done_count", 64'(dcount), 64'd1);
    chk("ignore busy_end", 64'(bus.Busy), 64'd0);
    last = '{"ign", 2'b00, 32'd3, 32'd4, 32'd0, 2'b00,
             32'd12, 32'd0, 4'b0000};

    // Flush at BUSY cycle 10.
    issue(2'b10, 32'hFFFFFFFF, 32'h3, 32'd0, 2'b11);
    repeat (10) @(posedge clk);
    #1;
    bus.Flush = 1'b1;
    @(posedge clk);
    #1;
    bus.Flush = 1'b0;
    chk("flush busy", 64'(bus.Busy), 64'd0);
    dcount = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (bus.Done) dcount++;
    end
    chk("flush no_done", 64'(dcount), 64'd0);
    chk("flush lo_hold", 64'(bus.ResultLo), 64'(last.lo));
    chk("flush hi_hold", 64'(bus.ResultHi), 64'(last.hi));
    chk("flush fl_hold", 64'(bus.ALUFlags), 64'(last.fl));
    run_vec(vt[0]);

    // Flush and Start together in IDLE: nothing is accepted.
    @(negedge clk);
    bus.Start = 1'b1;
    bus.Flush = 1'b1;
    bus.Op    = 2'b00;
    @(posedge clk);
    #1;
    bus.Start = 1'b0;
    bus.Flush = 1'b0;
    chk("flush_start busy", 64'(bus.Busy), 64'd0);
    dcount = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (bus.Done) dcount++;
    end
    chk("flush_start no_done", 64'(dcount), 64'd0);

    // Asynchronous reset at BUSY cycle 20.
    issue(2'b11, 32'hFFFFFFFE, 32'h3, 32'd0, 2'b11);
    repeat (20) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("areset busy", 64'(bus.Busy), 64'd0);
    chk("areset done", 64'(bus.Done), 64'd0);
    chk("areset lo", 64'(bus.ResultLo), 64'd0);
    chk("areset hi", 64'(bus.ResultHi), 64'd0);
    chk("areset flags", 64'(bus.ALUFlags), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    dcount = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (bus.Done) dcount++;
    end
    chk("areset no_done", 64'(dcount), 64'd0);
    mulv = '{"mul_3x5", 2'b00, 32'd3, 32'd5, 32'd0, 2'b01,
             32'd15, 32'd0, 4'b0001};
    run_vec(mulv);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
